// File: rtl/mac_rx_unloader_pkg.sv
// rtl/mac_rx_unloader_pkg.sv - shared types and buffer word layout for the MAC RX unloader
package mac_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEN   = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [1:0] BE_4 = 2'b00;
    localparam logic [1:0] BE_1 = 2'b01;
    localparam logic [1:0] BE_2 = 2'b10;
    localparam logic [1:0] BE_3 = 2'b11;

    localparam int ERR_BIT = 36;
    localparam int BE_HI   = 35;
    localparam int BE_LO   = 34;
    localparam int EOP_BIT = 33;
    localparam int SOP_BIT = 32;

    function automatic logic [2:0] be_bytes(input logic [1:0] be);
        case (be)
            BE_1:    return 3'd1;
            BE_2:    return 3'd2;
            BE_3:    return 3'd3;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mac_rx_unloader_if.sv
// rtl/mac_rx_unloader_if.sv - MAC RX, length FIFO, packet buffer and status signal bundle
interface mac_rx_unloader_if;

    logic        Rx_mac_ra;
    logic        Rx_mac_rd;
    logic        Rx_mac_pa;
    logic [31:0] Rx_mac_data;
    logic [1:0]  Rx_mac_BE;
    logic        Rx_mac_sop;
    logic        Rx_mac_eop;

    logic        Pkg_lgth_fifo_ra;
    logic        Pkg_lgth_fifo_rd;
    logic [15:0] Pkg_lgth_fifo_data;

    logic        buf_wr;
    logic [36:0] buf_din;
    logic        buf_afull;

    logic        pkt_done;
    logic        pkt_err;
    logic [15:0] pkt_cnt;
    logic [15:0] err_cnt;

    modport master (
        input  Rx_mac_ra, Rx_mac_pa, Rx_mac_data, Rx_mac_BE, Rx_mac_sop, Rx_mac_eop,
        input  Pkg_lgth_fifo_ra, Pkg_lgth_fifo_data, buf_afull,
        output Rx_mac_rd, Pkg_lgth_fifo_rd, buf_wr, buf_din,
        output pkt_done, pkt_err, pkt_cnt, err_cnt
    );

    modport slave (
        output Rx_mac_ra, Rx_mac_pa, Rx_mac_data, Rx_mac_BE, Rx_mac_sop, Rx_mac_eop,
        output Pkg_lgth_fifo_ra, Pkg_lgth_fifo_data, buf_afull,
        input  Rx_mac_rd, Pkg_lgth_fifo_rd, buf_wr, buf_din,
        input  pkt_done, pkt_err, pkt_cnt, err_cnt
    );

endinterface

// File: rtl/mac_rx_unloader.sv
// rtl/mac_rx_unloader.sv - drains MAC RX frames into the packet buffer, checking framing and length
module mac_rx_unloader #(
    parameter int MAX_WORDS = 384
) (
    input  logic              Clk_user,
    input  logic              Reset,
    mac_rx_unloader_if.master bus
);
    import mac_rx_pkg::*;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] len_r;
    logic        len_load;
    logic [10:0] wcnt;
    logic        err_r;
    logic        rd;
    logic        fifo_rd_nxt;
    logic        eop_in;
    logic        overrun;
    logic        first_err;
    logic        late_sop;
    logic        len_bad;
    logic        frame_err;
    logic [15:0] byte_total;
    logic [36:0] word;
    logic [36:0] term_word;

    // wcnt counts words already written, so on the eop word it equals words-1
    assign eop_in     = bus.Rx_mac_pa & bus.Rx_mac_eop;
    assign first_err  = (wcnt == 11'd0) & ~bus.Rx_mac_sop;
    assign late_sop   = (wcnt != 11'd0) & bus.Rx_mac_sop;
    assign byte_total = {3'b000, wcnt, 2'b00} + {13'd0, be_bytes(bus.Rx_mac_BE)};
    assign len_bad    = (byte_total != len_r);
    assign frame_err  = err_r | first_err | late_sop | (bus.Rx_mac_eop & len_bad);
    assign overrun    = bus.Rx_mac_pa & ~bus.Rx_mac_eop & (wcnt == 11'(MAX_WORDS));

    always_comb begin
        word                = '0;
        word[31:0]          = bus.Rx_mac_data;
        word[SOP_BIT]       = bus.Rx_mac_sop;
        word[EOP_BIT]       = bus.Rx_mac_eop;
        word[BE_HI:BE_LO]   = bus.Rx_mac_eop ? bus.Rx_mac_BE : BE_4;
        word[ERR_BIT]       = bus.Rx_mac_eop & frame_err;
        term_word           = '0;
        term_word[ERR_BIT]  = 1'b1;
        term_word[EOP_BIT]  = 1'b1;
    end

    always_ff @(posedge Clk_user or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Reads stop in the eop cycle so the next frame stays in the MAC until its length is popped
    always_comb begin
        state_nxt   = state;
        rd          = 1'b0;
        fifo_rd_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Pkg_lgth_fifo_ra & bus.Rx_mac_ra & ~bus.buf_afull) begin
                    fifo_rd_nxt = 1'b1;
                    state_nxt   = LEN;
                end
            end
            LEN: state_nxt = DATA;
            DATA: begin
                rd = bus.Rx_mac_ra & ~bus.buf_afull & ~eop_in;
                if (eop_in)       state_nxt = IDLE;
                else if (overrun) state_nxt = DRAIN;
            end
            DRAIN: begin
                rd = bus.Rx_mac_ra & ~eop_in;
                if (eop_in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.Rx_mac_rd = rd;

    always_ff @(posedge Clk_user or posedge Reset) begin
        if (Reset) begin
            bus.Pkg_lgth_fifo_rd <= 1'b0;
            bus.buf_wr           <= 1'b0;
            bus.buf_din          <= '0;
            bus.pkt_done         <= 1'b0;
            bus.pkt_err          <= 1'b0;
            bus.pkt_cnt          <= '0;
            bus.err_cnt          <= '0;
            len_r                <= '0;
            len_load             <= 1'b0;
            wcnt                 <= '0;
            err_r                <= 1'b0;
        end else begin
            bus.Pkg_lgth_fifo_rd <= fifo_rd_nxt;
            bus.buf_wr           <= 1'b0;
            bus.pkt_done         <= 1'b0;
            bus.pkt_err          <= 1'b0;
            // FIFO data is valid the cycle after the pop, i.e. the first DATA cycle
            len_load             <= (state == LEN);
            if (len_load) len_r <= bus.Pkg_lgth_fifo_data;
            case (state)
                LEN: begin
                    wcnt  <= '0;
                    err_r <= 1'b0;
                end
                DATA: begin
                    if (bus.Rx_mac_pa && !overrun) begin
                        bus.buf_wr  <= 1'b1;
                        bus.buf_din <= word;
                        wcnt        <= wcnt + 11'd1;
                        err_r       <= err_r | first_err | late_sop;
                        if (bus.Rx_mac_eop) begin
                            if (frame_err) begin
                                bus.pkt_err <= 1'b1;
                                bus.err_cnt <= bus.err_cnt + 16'd1;
                            end else begin
                                bus.pkt_done <= 1'b1;
                                bus.pkt_cnt  <= bus.pkt_cnt + 16'd1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (eop_in) begin
                        bus.buf_wr  <= 1'b1;
                        bus.buf_din <= term_word;
                        bus.pkt_err <= 1'b1;
                        bus.err_cnt <= bus.err_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
